alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, 16, operand/result width; SHALL match the ALU datapath width.
REQ-002 Parameter OPC_W, 8, opcode width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-007 reqN_ready  out  1  operation from requester N accepted this cycle.
REQ-008 reqN_opcode  in  OPC_W  operation code.
REQ-009 reqN_a, reqN_b  in  DATA_W  operands, driven to ALU r1/r2.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_id  out  1  requester owning the response.
REQ-012 rsp_ready  in  1  owning requester consumes the response.
REQ-013 rsp_result  out  DATA_W  registered ALU result.
REQ-014 rsp_flags  out  8  registered ALU flags for this operation.
REQ-015 rsp_err  out  1  opcode not in the legal set.
REQ-016 alu_r1, alu_r2, alu_opcode, alu_flags_in  out  DATA_W/DATA_W/OPC_W/8  drive the shared ALU.
REQ-017 alu_rout, alu_flags_out  in  DATA_W/8  ALU combinational results.
REQ-018 psr  out  8  program status register (C=0, L=2, F=5, Z=6, N=7).

Function
REQ-019 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-020 IDLE: if any reqN_valid, grant one, pulse reqN_ready for exactly that cycle, capture opcode/operands/id, go to EXEC.
REQ-021 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; after reset requester 0 has priority.
REQ-022 reqN_ready SHALL be 0 in EXEC and RESP, and 0 for a non-granted requester.
REQ-023 EXEC: alu_* driven from captured values, alu_flags_in = psr; at end of cycle alu_rout/alu_flags_out registered into rsp_result/rsp_flags; go to RESP.
REQ-024 Latency: grant in cycle T, rsp_valid high from cycle T+2.
REQ-025 RESP: rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err held stable until rsp_ready=1; then go to IDLE (no same-cycle re-grant).
REQ-026 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-027 Legal opcodes: 01,02,03,04,05,06,07,08,09,0B,0C,0F,84 (hex).
REQ-028 Illegal opcode: ALU not consulted, rsp_result=0, rsp_flags=0, rsp_err=1, psr unchanged; still takes EXEC and RESP (same latency).
REQ-029 psr SHALL load alu_flags_out at end of EXEC only for add(05), sub(09), cmp(0B); unchanged otherwise.
REQ-030 alu_* outputs SHALL be 0 outside EXEC.
REQ-031 reqN inputs changing after grant SHALL NOT affect the in-flight operation.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, psr=0, alu_* = 0, round-robin pointer to requester 0.
REQ-033 Reset during EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-034 First grant possible on the first rising edge with rst_n high.

Structure
REQ-035 Shared package SHALL hold opcode constants, flag bit indices, the FSM state enum and DATA_W/OPC_W defaults.
REQ-036 Round-robin grant logic SHALL be a sub-module rr_arb2 (2 requests, grant, pointer update on accept).
REQ-037 The ALU SHALL be instantiated outside this block; connection only via alu_* ports.

Verification
REQ-038 req0 add a=7FFF b=0001 -> grant T, rsp_valid T+2, rsp_result=8000, rsp_flags=20, psr=20, rsp_err=0.
REQ-039 Both valid after reset: req0 cmp 0005/0005, req1 xor F0F0/0FF0 -> req0 first (rsp_flags=40, psr=40), then req1 (rsp_result=FF00, psr stays 40).
REQ-040 rsp_ready low 5 cycles in RESP -> rsp_* stable, no reqN_ready pulse; release -> IDLE next cycle.
REQ-041 req1 opcode FF -> rsp_err=1, rsp_result=0000, psr unchanged, latency 2.
REQ-042 rst_n asserted in EXEC -> all outputs zero asynchronously, no response after release; next request to req1 alone granted normally.
REQ-043 Both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, opcodes,
// PSR flag positions, FSM states and the captured-operation control word.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OPC_W_DEF  = 8;
  localparam int unsigned FLAG_W     = 8;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_F = 5;
  localparam int unsigned FLAG_Z = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [OPC_W_DEF-1:0] OPC_01  = 8'h01;
  localparam logic [OPC_W_DEF-1:0] OPC_02  = 8'h02;
  localparam logic [OPC_W_DEF-1:0] OPC_03  = 8'h03;
  localparam logic [OPC_W_DEF-1:0] OPC_04  = 8'h04;
  localparam logic [OPC_W_DEF-1:0] OPC_ADD = 8'h05;
  localparam logic [OPC_W_DEF-1:0] OPC_06  = 8'h06;
  localparam logic [OPC_W_DEF-1:0] OPC_07  = 8'h07;
  localparam logic [OPC_W_DEF-1:0] OPC_08  = 8'h08;
  localparam logic [OPC_W_DEF-1:0] OPC_SUB = 8'h09;
  localparam logic [OPC_W_DEF-1:0] OPC_CMP = 8'h0B;
  localparam logic [OPC_W_DEF-1:0] OPC_0C  = 8'h0C;
  localparam logic [OPC_W_DEF-1:0] OPC_0F  = 8'h0F;
  localparam logic [OPC_W_DEF-1:0] OPC_84  = 8'h84;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Control bits captured at grant alongside the operands.
  typedef struct packed {
    logic id;
    logic legal;
    logic psr_ld;
  } op_ctrl_t;

  function automatic logic opc_legal(input logic [OPC_W_DEF-1:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_01, OPC_02, OPC_03, OPC_04, OPC_ADD, OPC_06, OPC_07,
      OPC_08, OPC_SUB, OPC_CMP, OPC_0C, OPC_0F, OPC_84: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic opc_sets_psr(input logic [OPC_W_DEF-1:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_CMP);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
);

  logic              req0_valid;
  logic              req0_ready;
  logic [OPC_W-1:0]  req0_opcode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OPC_W-1:0]  req1_opcode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [FLAG_W-1:0] rsp_flags;
  logic              rsp_err;

  logic [DATA_W-1:0] alu_r1;
  logic [DATA_W-1:0] alu_r2;
  logic [OPC_W-1:0]  alu_opcode;
  logic [FLAG_W-1:0] alu_flags_in;
  logic [DATA_W-1:0] alu_rout;
  logic [FLAG_W-1:0] alu_flags_out;

  logic [FLAG_W-1:0] psr;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  rsp_ready, alu_rout, alu_flags_out,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output alu_r1, alu_r2, alu_opcode, alu_flags_in, psr
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output rsp_ready, alu_rout, alu_flags_out,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  alu_r1, alu_r2, alu_opcode, alu_flags_in, psr
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last
// wins; the pointer advances only when the grant is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_c
);

  // Index of the requester that wins the next contention.
  logic ptr;

  always_comb begin
    grant_c = 2'b00;
    if (req == 2'b11) begin
      grant_c = ptr ? 2'b10 : 2'b01;
    end else begin
      grant_c = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept && (grant_c != 2'b00)) begin
      ptr <= grant_c[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; one operation in flight,
// fixed two-cycle grant-to-response latency, PSR updated by add/sub/cmp.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  state_t            state;
  op_ctrl_t          ctrl;

  logic [1:0]        req;
  logic [1:0]        grant_c;
  logic              accept_c;
  logic              sel1_c;
  logic              legal_c;
  logic              psr_ld_c;
  logic [OPC_W-1:0]  opc_c;
  logic [DATA_W-1:0] a_c;
  logic [DATA_W-1:0] b_c;

  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_result;
  logic [FLAG_W-1:0] rsp_flags;
  logic [FLAG_W-1:0] psr;
  logic [DATA_W-1:0] alu_r1;
  logic [DATA_W-1:0] alu_r2;
  logic [OPC_W-1:0]  alu_opcode;
  logic [FLAG_W-1:0] alu_flags_in;

  assign req = {bus.req1_valid, bus.req0_valid};

  // Reset gating keeps ready low while rst_n is held, although IDLE is already the reset state.
  assign accept_c = rst_n && (state == ST_IDLE) && (req != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .accept  (accept_c),
    .grant_c (grant_c)
  );

  assign bus.req0_ready = accept_c & grant_c[0];
  assign bus.req1_ready = accept_c & grant_c[1];

  assign sel1_c   = grant_c[1];
  assign opc_c    = sel1_c ? bus.req1_opcode : bus.req0_opcode;
  assign a_c      = sel1_c ? bus.req1_a      : bus.req0_a;
  assign b_c      = sel1_c ? bus.req1_b      : bus.req0_b;
  assign legal_c  = opc_legal(OPC_W_DEF'(opc_c));
  assign psr_ld_c = legal_c && opc_sets_psr(OPC_W_DEF'(opc_c));

  // alu_* are loaded at grant so they are valid for exactly the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ctrl         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      psr          <= '0;
      alu_r1       <= '0;
      alu_r2       <= '0;
      alu_opcode   <= '0;
      alu_flags_in <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state       <= ST_EXEC;
            ctrl.id     <= sel1_c;
            ctrl.legal  <= legal_c;
            ctrl.psr_ld <= psr_ld_c;
            // An illegal opcode leaves the ALU idle for the whole operation.
            if (legal_c) begin
              alu_r1       <= a_c;
              alu_r2       <= b_c;
              alu_opcode   <= opc_c;
              alu_flags_in <= psr;
            end
          end
        end

        ST_EXEC: begin
          state        <= ST_RESP;
          alu_r1       <= '0;
          alu_r2       <= '0;
          alu_opcode   <= '0;
          alu_flags_in <= '0;
          rsp_valid    <= 1'b1;
          rsp_id       <= ctrl.id;
          rsp_err      <= ~ctrl.legal;
          rsp_result   <= ctrl.legal ? bus.alu_rout : '0;
          rsp_flags    <= ctrl.legal ? bus.alu_flags_out : '0;
          if (ctrl.psr_ld) begin
            psr <= bus.alu_flags_out;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_id       = rsp_id;
  assign bus.rsp_err      = rsp_err;
  assign bus.rsp_result   = rsp_result;
  assign bus.rsp_flags    = rsp_flags;
  assign bus.psr          = psr;
  assign bus.alu_r1       = alu_r1;
  assign bus.alu_r2       = alu_r2;
  assign bus.alu_opcode   = alu_opcode;
  assign bus.alu_flags_in = alu_flags_in;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached to alu_*.
module tb_alu_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 8;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic [7:0]  flags;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model_psr = 8'h00;
  exp_t        sb[$];
  logic [15:0] tb_rout;
  logic [7:0]  tb_fout;
  logic [7:0]  legal_ops [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                  8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84};

  alu_arbiter_if #(.DATA_W(DW), .OPC_W(OW)) bus ();

  alu_arbiter #(.DATA_W(DW), .OPC_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: add/sub set C/F/Z, cmp sets L/Z, other ops pass flags through.
  function automatic void alu_model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [7:0] fin, output logic [15:0] r, output logic [7:0] f);
    logic [16:0] s;
    r = 16'h0000;
    f = fin;
    s = 17'h0;
    case (op)
      8'h01: r = a;
      8'h02: r = a & b;
      8'h03: r = a | b;
      8'h04: r = ~a;
      8'h06: r = a << 1;
      8'h07: r = a >> 1;
      8'h08: r = a + 16'd1;
      8'h0C: r = a ^ b;
      8'h0F: r = b;
      8'h84: r = {a[7:0], a[15:8]};
      8'h05: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        f = 8'h00;
        f[0] = s[16];
        f[5] = (a[15] == b[15]) && (r[15] != a[15]);
        f[6] = (r == 16'h0000);
      end
      8'h09: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0];
        f = 8'h00;
        f[0] = s[16];
        f[5] = (a[15] != b[15]) && (r[15] != a[15]);
        f[6] = (r == 16'h0000);
      end
      8'h0B: begin
        f = 8'h00;
        f[2] = (a < b);
        f[6] = (a == b);
      end
      default: begin
        r = 16'h0000;
        f = 8'h00;
      end
    endcase
  endfunction

  always_comb alu_model(bus.alu_opcode, bus.alu_r1, bus.alu_r2, bus.alu_flags_in, tb_rout, tb_fout);
  assign bus.alu_rout      = tb_rout;
  assign bus.alu_flags_out = tb_fout;

  task automatic push_expected(input logic id, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.id = id;
    if (!(op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84})) begin
      e.res = 16'h0000; e.flags = 8'h00; e.err = 1'b1;
    end else begin
      alu_model(op, a, b, model_psr, e.res, e.flags);
      e.err = 1'b0;
      if (op == 8'h05 || op == 8'h09 || op == 8'h0B) model_psr = e.flags;
    end
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e = '{default: '0};
    if (ok) e = sb.pop_front();
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Called at edge+1; returns at edge+1 of the cycle after the grant.
  task automatic wait_grant(output int gid, output int gc, output bit ok);
    ok = 0; gid = -1; gc = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (bus.req0_ready || bus.req1_ready) begin
        ok = 1; gc = cyc;
        gid = bus.req1_ready ? 1 : 0;
        if (gid == 1) push_expected(1'b1, bus.req1_opcode, bus.req1_a, bus.req1_b);
        else          push_expected(1'b0, bus.req0_opcode, bus.req0_a, bus.req0_b);
      end
      @(posedge clk); #1;
      if (ok) break;
    end
  endtask

  task automatic wait_rsp(output bit ok, output int rc);
    ok = 0; rc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin ok = 1; rc = cyc; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_psr = 8'h00;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'h05, 16'h0001, 16'h0002);
    set_req(1, 1'b1, 8'h09, 16'h0003, 16'h0004);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_flags} !== 27'h0) begin
      failures++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_flags});
    end
    checks++;
    if ({bus.psr, bus.alu_r1, bus.alu_r2, bus.alu_opcode, bus.alu_flags_in} !== 56'h0) begin
      failures++; $display("FAIL reset_psr_alu: got %h expected 0", {bus.psr, bus.alu_r1, bus.alu_r2, bus.alu_opcode, bus.alu_flags_in});
    end
    set_req(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    set_req(1, 1'b0, 8'h00, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    model_psr = 8'h00;
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int gid, gc, rc; bit ok, have; exp_t e;
    set_req(0, 1'b1, 8'h05, 16'h7FFF, 16'h0001);
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 0) begin failures++; $display("FAIL add_grant: got %0d expected 0", gid); return; end
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.alu_opcode, bus.alu_r1, bus.alu_r2, bus.alu_flags_in} !== {2'b00, 8'h05, 16'h7FFF, 16'h0001, 8'h00}) begin
      failures++; $display("FAIL add_exec_drive: got %h expected 0057fff000100",
                           {bus.req0_ready, bus.req1_ready, bus.alu_opcode, bus.alu_r1, bus.alu_r2, bus.alu_flags_in});
    end
    set_req(0, 1'b0, 8'h09, 16'h1234, 16'h4321);
    wait_rsp(ok, rc);
    checks++;
    if (!ok || rc - gc != 2) begin failures++; $display("FAIL add_latency: got %0d expected 2", rc - gc); return; end
    pop_exp(e, have);
    checks++;
    if (!have || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {e.id, e.res, e.flags, e.err}) begin
      failures++; $display("FAIL add_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err}, {e.id, e.res, e.flags, e.err});
    end
    checks++;
    if ({bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr} !== {16'h8000, 8'h20, 1'b0, 8'h20}) begin
      failures++; $display("FAIL add_values: got %h expected 8000_20_0_20", {bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr});
    end
    consume();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL add_release: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_both_valid();
    int gid, gc, rc; bit ok, have; exp_t e;
    apply_reset();
    set_req(0, 1'b1, 8'h0B, 16'h0005, 16'h0005);
    set_req(1, 1'b1, 8'h0C, 16'hF0F0, 16'h0FF0);
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 0) begin failures++; $display("FAIL both_first: got %0d expected 0", gid); return; end
    bus.req0_valid = 1'b0;
    #3;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL both_exec_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    end
    wait_rsp(ok, rc);
    pop_exp(e, have);
    checks++;
    if (!ok || !have || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr} !== {e.id, e.res, e.flags, e.err, 8'h40}) begin
      failures++; $display("FAIL both_cmp_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr}, {e.id, e.res, e.flags, e.err, 8'h40});
    end
    checks++;
    if (bus.rsp_flags !== 8'h40) begin failures++; $display("FAIL both_cmp_flags: got %h expected 40", bus.rsp_flags); end
    consume();
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 1) begin failures++; $display("FAIL both_second: got %0d expected 1", gid); return; end
    bus.req1_valid = 1'b0;
    wait_rsp(ok, rc);
    pop_exp(e, have);
    checks++;
    if (!ok || !have || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {e.id, e.res, e.flags, e.err}) begin
      failures++; $display("FAIL both_xor_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err}, {e.id, e.res, e.flags, e.err});
    end
    checks++;
    if ({bus.rsp_result, bus.psr} !== {16'hFF00, 8'h40}) begin
      failures++; $display("FAIL both_xor_values: got %h expected ff0040", {bus.rsp_result, bus.psr});
    end
    consume();
  endtask

  task automatic test_backpressure();
    int gid, gc, rc; bit ok, have; exp_t e;
    set_req(0, 1'b1, 8'h02, 16'hA5A5, 16'h0FF0);
    set_req(1, 1'b1, 8'h0F, 16'h1111, 16'h2222);
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 0) begin failures++; $display("FAIL bp_grant: got %0d expected 0", gid); return; end
    bus.req0_valid = 1'b0;
    wait_rsp(ok, rc);
    pop_exp(e, have);
    checks++;
    if (!ok || !have || rc - gc != 2) begin failures++; $display("FAIL bp_latency: got %0d expected 2", rc - gc); return; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !==
          {2'b00, 1'b1, e.id, e.res, e.flags, e.err}) begin
        failures++; $display("FAIL bp_hold: cycle %0d got %h expected %h", i,
                             {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err},
                             {2'b00, 1'b1, e.id, e.res, e.flags, e.err});
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #3;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL bp_same_cycle_grant: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_idle: got %b expected 0", bus.rsp_valid); end
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 1) begin failures++; $display("FAIL bp_next_grant: got %0d expected 1", gid); return; end
    bus.req1_valid = 1'b0;
    wait_rsp(ok, rc);
    pop_exp(e, have);
    checks++;
    if (!ok || !have || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {e.id, e.res, e.flags, e.err}) begin
      failures++; $display("FAIL bp_second_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err}, {e.id, e.res, e.flags, e.err});
    end
    consume();
  endtask

  task automatic test_illegal();
    int gid, gc, rc; bit ok, have; exp_t e;
    bus.rsp_ready = 1'b1;
    set_req(1, 1'b1, 8'hFF, 16'h1234, 16'h5678);
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 1) begin failures++; bus.rsp_ready = 1'b0; $display("FAIL ill_grant: got %0d expected 1", gid); return; end
    bus.req1_valid = 1'b0;
    checks++;
    if (bus.alu_opcode !== 8'h00) begin failures++; $display("FAIL ill_alu_idle: got %h expected 00", bus.alu_opcode); end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    wait_rsp(ok, rc);
    pop_exp(e, have);
    checks++;
    if (!ok || rc - gc != 2) begin failures++; $display("FAIL ill_latency: got %0d expected 2", rc - gc); return; end
    checks++;
    if (!have || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr} !== {e.id, e.res, e.flags, e.err, model_psr}) begin
      failures++; $display("FAIL ill_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr}, {e.id, e.res, e.flags, e.err, model_psr});
    end
    checks++;
    if ({bus.rsp_err, bus.rsp_result, bus.psr} !== {1'b1, 16'h0000, 8'h40}) begin
      failures++; $display("FAIL ill_values: got %h expected 1_0000_40", {bus.rsp_err, bus.rsp_result, bus.psr});
    end
    consume();
  endtask

  task automatic test_reset_exec();
    int gid, gc, rc; bit ok, have, seen; exp_t e;
    set_req(0, 1'b1, 8'h05, 16'h1000, 16'h2000);
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 0) begin failures++; $display("FAIL rstx_grant: got %0d expected 0", gid); return; end
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_flags, bus.psr,
         bus.alu_r1, bus.alu_r2, bus.alu_opcode, bus.alu_flags_in} !== 85'h0) begin
      failures++; $display("FAIL rstx_async_clear: got %h expected 0",
                           {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_flags, bus.psr,
                            bus.alu_r1, bus.alu_r2, bus.alu_opcode, bus.alu_flags_in});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_psr = 8'h00;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL rstx_no_rsp: got 1 expected 0"); end
    set_req(1, 1'b1, 8'h09, 16'h0003, 16'h0005);
    wait_grant(gid, gc, ok);
    checks++;
    if (!ok || gid != 1) begin failures++; $display("FAIL rstx_req1_grant: got %0d expected 1", gid); return; end
    bus.req1_valid = 1'b0;
    wait_rsp(ok, rc);
    pop_exp(e, have);
    checks++;
    if (!ok || !have || rc - gc != 2 || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr} !== {e.id, e.res, e.flags, e.err, model_psr}) begin
      failures++; $display("FAIL rstx_req1_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr}, {e.id, e.res, e.flags, e.err, model_psr});
    end
    checks++;
    if ({bus.rsp_result, bus.rsp_flags} !== {16'hFFFE, 8'h01}) begin
      failures++; $display("FAIL rstx_sub_values: got %h expected fffe01", {bus.rsp_result, bus.rsp_flags});
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int gid, gc, rc; bit ok, have; exp_t e;
    set_req(0, 1'b1, 8'h05, 16'h8000, 16'h8000);
    set_req(1, 1'b1, 8'h09, 16'h0010, 16'h0010);
    for (int i = 0; i < 6; i++) begin
      wait_grant(gid, gc, ok);
      checks++;
      if (!ok || gid != (i % 2)) begin failures++; $display("FAIL rr_order: op %0d got %0d expected %0d", i, gid, i % 2); break; end
      set_req(gid, 1'b1, legal_ops[$urandom_range(12, 0)], 16'($urandom), 16'($urandom));
      wait_rsp(ok, rc);
      pop_exp(e, have);
      checks++;
      if (!ok || !have || rc - gc != 2 || {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr} !== {e.id, e.res, e.flags, e.err, model_psr}) begin
        failures++; $display("FAIL rr_rsp: op %0d got %h expected %h", i, {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.psr}, {e.id, e.res, e.flags, e.err, model_psr});
      end
      consume();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_both_valid();
    test_backpressure();
    test_illegal();
    test_reset_exec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
